dmem_banked_responder: RTL and testbench
========================================

Name: dmem_banked_responder

Overview:
- Memory-side responder for the data-memory request interface: 13-bit address, `read_write` strobe, 32-bit write data, 32-bit read data.
- Storage is 8 banks × 1024 words × 32 bits. `address[12:10]` selects the bank and `address[9:0]` selects the word offset.
- Adds a valid/ready request handshake, a buffered read-response path with backpressure, and a post-reset zero-fill sequencer, so the core or a bench can drive it as an initiator.

Parameters:
- DATA_W, 32, data word width.
- BANK_BITS, 3, bank-select bits (address MSBs).
- OFFSET_BITS, 10, word-offset bits (address LSBs).
- RESP_DEPTH, 2, read-response buffer entries (≥1).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- address  in  BANK_BITS+OFFSET_BITS  {bank, offset}.
- read_write  in  1  1 = write, 0 = read.
- data_in  in  DATA_W  write data.
- resp_valid  out  1  read data available.
- resp_ready  in  1  consumer takes the read data.
- dataOut  out  DATA_W  read data at the head of the response buffer.
- init_done  out  1  zero-fill complete.

Behaviour:
- Reset values (asynchronous):
  - state = INIT, init_cnt = 0.
  - req_ready = 0, resp_valid = 0, dataOut = 0, init_done = 0.
  - Response buffer empty, rd_pending = 0.
- State INIT:
  - Each cycle writes 0 to offset init_cnt in all banks in parallel, then init_cnt increments.
  - After the cycle with init_cnt = 2^OFFSET_BITS−1, go to RUN and set init_done = 1. That is 1024 cycles after reset deasserts.
  - req_ready = 0 throughout INIT.
- State RUN:
  - Accept condition: req_valid && req_ready.
  - req_ready = (count + rd_pending < RESP_DEPTH). A pop in the same cycle earns no credit.
- Write on accept:
  - bank[address[12:10]][address[9:0]] ← data_in at that edge.
  - Writes produce no response.
- Read on accept:
  - A synchronous RAM read is issued and rd_pending = 1.
  - On the next edge the data is pushed to the buffer tail. resp_valid is therefore high 1 cycle after acceptance if the buffer was empty.
- Response buffer:
  - FIFO with RESP_DEPTH entries.
  - resp_valid = (count ≠ 0); dataOut = head entry.
  - Pop on resp_valid && resp_ready.
  - Simultaneous push and pop leave count unchanged and keep data in order.
  - Overflow is impossible by the credit rule above; verification asserts this.
- Ordering and hazards:
  - Reads return strictly in acceptance order.
  - Read-after-write to the same address in the next cycle returns the new data; one request per cycle means no same-cycle conflict.
- Addressing:
  - All 13 address bits are decoded; there are no out-of-range addresses.
  - Offset 0 of each bank is a distinct word (no aliasing between banks).
- Reset mid-operation:
  - Buffered and pending reads are discarded.
  - Outputs return to their reset values immediately.
  - INIT reruns, so all contents read 0 afterwards.
- Idle / X handling: data_in, address and read_write are ignored when req_valid = 0.

Decomposition:
- Shared package dmem_pkg holds:
  - DATA_W, BANK_BITS, OFFSET_BITS and NUM_BANKS = 2^BANK_BITS.
  - Address field slice helpers (bank_of, offset_of).
  - The RW_WRITE = 1 / RW_READ = 0 constants.
  - The state enum {INIT, RUN}.
- One sub-module, dmem_bank:
  - Single-port synchronous RAM, 2^OFFSET_BITS × DATA_W.
  - Ports: we, addr, wdata, rdata; read data registered 1 cycle.
  - Instantiated NUM_BANKS times via generate.
  - A registered bank index muxes the 8 rdata outputs.

Test Plan:
- Reset, then idle → req_ready = 0 and init_done = 0 for exactly 1024 cycles, then both go to 1. Read 0x1FFF → dataOut = 0x00000000.
- Write 0xA5A5A5A5 to bank 0 offset 0, then read the same address next cycle → resp_valid rises 1 cycle after read acceptance with dataOut = 0xA5A5A5A5.
- Writes of 0x12345678 (b1 o4), 0x15328054 (b2 o8), 0x00100234 (b3 o12), 0x53601518 (b4 o0), then back-to-back reads in the same order with resp_ready = 1 → four responses in order, one per cycle.
- Hold resp_ready = 0 and issue 3 consecutive reads → only 2 accepted and req_ready drops. Raise resp_ready → both data words delivered in order, then the 3rd read is accepted.
- Write 0x69420632 to b5 o4 and 0x97319711 to b7 o4, then read both → distinct values returned (no bank aliasing).
- With 2 responses buffered, assert reset for 1 cycle → resp_valid = 0 immediately. After re-init, reading b1 o4 → 0x00000000.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the banked data-memory responder.
//   DATA_W / BANK_BITS / OFFSET_BITS / NUM_BANKS : storage geometry
//   RW_WRITE / RW_READ                          : read_write strobe encoding
//   dmem_state_e                                : responder FSM states
//   bank_of / offset_of                         : address field slicing
package dmem_pkg;

    localparam int DATA_W      = 32;
    localparam int BANK_BITS   = 3;
    localparam int OFFSET_BITS = 10;
    localparam int NUM_BANKS   = 1 << BANK_BITS;
    localparam int ADDR_W      = BANK_BITS + OFFSET_BITS;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } dmem_state_e;

    // Bank select lives in the address MSBs.
    function automatic logic [BANK_BITS-1:0] bank_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:OFFSET_BITS];
    endfunction

    // Word offset lives in the address LSBs.
    function automatic logic [OFFSET_BITS-1:0] offset_of(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_BITS-1:0];
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port synchronous RAM bank, 2^ADDR_W words of DATA_W bits.
//   clock : rising-edge clock
//   we    : write enable (wdata stored at addr on the edge)
//   addr  : word address, shared by read and write
//   wdata : write data
//   rdata : registered read data (contents of addr before this edge's write)
module dmem_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Read-first: a read in the cycle after a write sees the new word,
    // because the write has already landed by the next edge.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_banked_responder.sv
// Banked data-memory responder: 8 banks x 1024 words, valid/ready request
// port, buffered read-response port with backpressure, zero-fill after reset.
//   clock, reset          : rising-edge clock, async active-high reset
//   req_valid / req_ready : request handshake
//   address               : {bank, offset}
//   read_write            : 1 = write, 0 = read
//   data_in               : write data
//   resp_valid/resp_ready : read-response handshake
//   dataOut               : head of the response buffer (0 when empty)
//   init_done             : zero-fill finished, requests may be accepted
//   state_dbg             : current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready does not depend on req_valid; resp_valid does not
// depend on resp_ready. A request stays as presented until it is accepted.
module dmem_banked_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W      = dmem_pkg::DATA_W,
    parameter int BANK_BITS   = dmem_pkg::BANK_BITS,
    parameter int OFFSET_BITS = dmem_pkg::OFFSET_BITS,
    parameter int RESP_DEPTH  = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [BANK_BITS+OFFSET_BITS-1:0] address,
    input  logic                           read_write,
    input  logic [DATA_W-1:0]              data_in,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [DATA_W-1:0]              dataOut,
    output logic                           init_done,
    output dmem_state_e                    state_dbg
);

    localparam int NB    = 1 << BANK_BITS;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam logic [OFFSET_BITS-1:0] LAST_OFFSET = '1;
    localparam logic [CNT_W:0]         DEPTH_L     = (CNT_W + 1)'(RESP_DEPTH);

    dmem_state_e state, state_next;
    logic [OFFSET_BITS-1:0] init_cnt, init_cnt_next;

    logic accept, rd_accept, rd_pending, push, pop;
    logic [BANK_BITS-1:0] rd_bank;

    logic [NB-1:0]          bank_we;
    logic [OFFSET_BITS-1:0] bank_addr;
    logic [DATA_W-1:0]      bank_wdata;
    logic [DATA_W-1:0]      bank_rdata [NB];

    logic [DATA_W-1:0] buf_mem [RESP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    credit_used;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // An in-flight read owns a buffer slot already, so it counts against
    // credit. A pop in the same cycle is deliberately not credited to keep
    // req_ready off the resp_ready path.
    assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, rd_pending};
    assign req_ready   = (state == RUN) && (credit_used < DEPTH_L);
    assign accept      = req_valid && req_ready;
    assign rd_accept   = accept && (read_write == RW_READ);

    assign init_done = (state == RUN);
    assign state_dbg = state;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_next;
            init_cnt <= init_cnt_next;
        end
    end

    // ---------------- FSM: next state and bank controls ----------------
    always_comb begin
        state_next    = state;
        init_cnt_next = init_cnt;
        bank_we       = '0;
        bank_addr     = offset_of(address);
        bank_wdata    = data_in;
        case (state)
            INIT: begin
                // Zero one offset in every bank per cycle.
                bank_we       = '1;
                bank_addr     = init_cnt;
                bank_wdata    = '0;
                init_cnt_next = init_cnt + 1'b1;
                if (init_cnt == LAST_OFFSET) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (accept && (read_write == RW_WRITE)) begin
                    bank_we[bank_of(address)] = 1'b1;
                end
            end
        endcase
    end

    // ---------------- RAM banks ----------------
    for (genvar b = 0; b < NB; b++) begin : g_bank
        dmem_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (OFFSET_BITS)
        ) u_bank (
            .clock (clock),
            .we    (bank_we[b]),
            .addr  (bank_addr),
            .wdata (bank_wdata),
            .rdata (bank_rdata[b])
        );
    end

    // Remember which bank the read went to; its rdata is valid next cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_pending <= 1'b0;
            rd_bank    <= '0;
        end else begin
            rd_pending <= rd_accept;
            if (rd_accept) begin
                rd_bank <= bank_of(address);
            end
        end
    end

    // ---------------- Response FIFO ----------------
    assign push       = rd_pending;
    assign resp_valid = (count != '0);
    assign pop        = resp_valid && resp_ready;
    assign dataOut    = resp_valid ? buf_mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (push) begin
            buf_mem[wr_ptr] <= bank_rdata[rd_bank];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_banked_responder.sv
// Bench for dmem_banked_responder: reference memory model, expected-read
// queue filled on request acceptance and drained on response transfer.
module tb_dmem_banked_responder;
    import dmem_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        read_write = 1'b0;
    logic        resp_ready = 1'b1;
    logic [12:0] address = '0;
    logic [31:0] data_in = '0;
    logic        req_ready, resp_valid, init_done;
    logic [31:0] dataOut;
    dmem_state_e state_dbg;

    always #5 clock = ~clock;

    dmem_banked_responder dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .address    (address),
        .read_write (read_write),
        .data_in    (data_in),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .dataOut    (dataOut),
        .init_done  (init_done),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] model [8192];
    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;
    int n_resp   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, so at the falling
    // edge both inputs and outputs show what the next rising edge will use.
    always @(negedge clock) begin
        if (!reset) begin
            if (resp_valid && resp_ready) begin
                n_resp++;
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("resp_data", dataOut, exp_q.pop_front());
                end
            end
            if (req_valid && req_ready) begin
                n_acc++;
                if (read_write == RW_WRITE) model[address] = data_in;
                else exp_q.push_back(model[address]);
            end
            if (dut.push) begin
                check("no_overflow", 32'(dut.count == 2 && !dut.pop), 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic zero_model();
        for (int i = 0; i < 8192; i++) model[i] = '0;
    endtask

    // Called just after a rising edge; returns just after the accepting edge
    // with the request still presented.
    task automatic do_req(input logic rw, input logic [12:0] a, input logic [31:0] d);
        int k;
        req_valid  = 1'b1;
        read_write = rw;
        address    = a;
        data_in    = d;
        k = 0;
        @(negedge clock);
        while (!req_ready && k < 200) begin
            k++;
            @(negedge clock);
        end
        check("req_accepted", 32'(req_ready), 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        req_valid  = 1'b0;
        read_write = 1'($urandom_range(0, 1));
        address    = 13'($urandom);
        data_in    = $urandom;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clock);
            k++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_init();
        int cyc, bad;
        cyc = 0;
        bad = 0;
        @(negedge clock);
        while (!init_done && cyc < 3000) begin
            if (req_ready) bad++;
            cyc++;
            @(negedge clock);
        end
        check("init_cycles", 32'(cyc), 32'd1024);
        check("init_ready_low", 32'(bad), 32'd0);
        check("init_done", 32'(init_done), 32'd1);
        check("ready_after_init", 32'(req_ready), 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_dataOut"}, dataOut, 32'd0);
        check({tag, "_init_done"}, 32'(init_done), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int r0, a0;
        logic done;
        logic [12:0] addr_set [4];
        zero_model();
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        wait_init();

        // Freshly initialised memory reads zero.
        do_req(RW_READ, 13'h1FFF, '0);
        idle();
        drain();

        // Write then read next cycle; one-cycle response latency.
        do_req(RW_WRITE, 13'h0000, 32'hA5A5A5A5);
        do_req(RW_READ, 13'h0000, '0);
        idle();
        @(negedge clock);
        check("lat_low", 32'(resp_valid), 32'd0);
        @(negedge clock);
        check("lat_high", 32'(resp_valid), 32'd1);
        check("lat_data", dataOut, 32'hA5A5A5A5);
        drain();

        // Four writes across banks, then reads back-to-back in order.
        do_req(RW_WRITE, 13'h0404, 32'h12345678);
        do_req(RW_WRITE, 13'h0808, 32'h15328054);
        do_req(RW_WRITE, 13'h0C0C, 32'h00100234);
        do_req(RW_WRITE, 13'h1000, 32'h53601518);
        r0 = n_resp;
        do_req(RW_READ, 13'h0404, '0);
        do_req(RW_READ, 13'h0808, '0);
        do_req(RW_READ, 13'h0C0C, '0);
        do_req(RW_READ, 13'h1000, '0);
        idle();
        drain();
        check("order_resp_count", 32'(n_resp - r0), 32'd4);

        // Backpressure: only two reads fit, the third waits for a pop.
        resp_ready = 1'b0;
        r0 = n_resp;
        a0 = n_acc;
        do_req(RW_READ, 13'h0404, '0);
        do_req(RW_READ, 13'h0808, '0);
        address = 13'h0C0C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("hold_ready_low", 32'(req_ready), 32'd0);
        end
        check("hold_accepts", 32'(n_acc - a0), 32'd2);
        check("hold_resp_valid", 32'(resp_valid), 32'd1);
        check("hold_head", dataOut, 32'h12345678);
        @(posedge clock);
        #1 resp_ready = 1'b1;
        do_req(RW_READ, 13'h0C0C, '0);
        idle();
        drain();
        check("hold_resp_count", 32'(n_resp - r0), 32'd3);

        // Same offset in different banks holds different words.
        do_req(RW_WRITE, 13'h1404, 32'h69420632);
        do_req(RW_WRITE, 13'h1C04, 32'h97319711);
        do_req(RW_READ, 13'h1404, '0);
        do_req(RW_READ, 13'h1C04, '0);
        idle();
        drain();

        // Mixed traffic on a few addresses with random backpressure.
        addr_set[0] = 13'h0005;
        addr_set[1] = 13'h0405;
        addr_set[2] = 13'h1C05;
        addr_set[3] = 13'h1FFF;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    do_req(1'($urandom_range(0, 1)), addr_set[$urandom_range(0, 3)], $urandom);
                    if ($urandom_range(0, 2) == 0) begin
                        idle();
                        @(posedge clock);
                        #1;
                    end
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clock);
                    #1 resp_ready = 1'($urandom_range(0, 1));
                end
                resp_ready = 1'b1;
            end
        join
        drain();

        // Reset with two responses buffered discards them and re-zeroes memory.
        resp_ready = 1'b0;
        do_req(RW_READ, 13'h0404, '0);
        do_req(RW_READ, 13'h0808, '0);
        idle();
        @(negedge clock);
        @(negedge clock);
        check("pre_reset_buffered", 32'(resp_valid), 32'd1);
        @(posedge clock);
        #1 reset = 1'b1;
        exp_q.delete();
        zero_model();
        #1;
        check_reset_outputs("midreset");
        resp_ready = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        wait_init();
        do_req(RW_READ, 13'h0404, '0);
        idle();
        @(negedge clock);
        @(negedge clock);
        check("post_reset_data", dataOut, 32'h00000000);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
